// File: rtl/fifo256_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo256_ctrl (plus its storage, fifo256_ram)
// Brief    : 256-entry first-word-fall-through FIFO controller built on a
//            256 x WIDTH dual-port distributed RAM. Provides occupancy,
//            almost-full, and sticky overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================

// 256 x WIDTH dual-port distributed RAM: synchronous per-bit write, async read
module fifo256_ram #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] we_i,
    input  logic [7:0]       waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [7:0]       raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Contents are never reset; only written bits change
    logic [WIDTH-1:0] mem [256];

    // Bit-enabled write into the addressed word
    always_ff @(posedge clk) begin
        for (int b = 0; b < WIDTH; b++) begin
            if (we_i[b]) begin
                mem[waddr_i][b] <= wdata_i[b];
            end
        end
    end

    // Read port is combinational so the head word falls through
    assign rdata_o = mem[raddr_i];

endmodule

module fifo256_ctrl #(
    parameter int WIDTH       = 32,
    parameter int AFULL_LEVEL = 192
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [8:0]       level,
    output logic             afull,
    output logic             ovf,
    output logic             unf
);

    localparam logic [8:0] C_FULL_LEVEL  = 9'd256;
    localparam logic [8:0] C_AFULL_LEVEL = 9'(AFULL_LEVEL);

    logic [7:0]       wr_ptr_q, wr_ptr_d;
    logic [7:0]       rd_ptr_q, rd_ptr_d;
    logic [8:0]       level_q,  level_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] ram_we;

    // Handshake flags come only from the level register, never from inputs
    assign wr_ready = (level_q != C_FULL_LEVEL);
    assign rd_valid = (level_q != 9'd0);
    assign level    = level_q;
    assign afull    = (level_q >= C_AFULL_LEVEL);
    assign ovf      = ovf_q;
    assign unf      = unf_q;

    // A flush cycle must not move data, so it gates both transfers
    assign push   = wr_valid & wr_ready & ~flush;
    assign pop    = rd_valid & rd_ready & ~flush;
    assign ram_we = {WIDTH{push}};

    fifo256_ram #(
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Next-state for pointers, occupancy and sticky error flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush) begin
            wr_ptr_d = 8'd0;
            rd_ptr_d = 8'd0;
            level_d  = 9'd0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 8'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 8'd1;
            end
            if (push && !pop) begin
                level_d = level_q + 9'd1;
            end else if (pop && !push) begin
                level_d = level_q - 9'd1;
            end
            if (wr_valid && !wr_ready) begin
                ovf_d = 1'b1;
            end
            if (rd_ready && !rd_valid) begin
                unf_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 8'd0;
            rd_ptr_q <= 8'd0;
            level_q  <= 9'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo256_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo256_ctrl
// Brief    : Self-checking bench for fifo256_ctrl: directed scenarios plus
//            randomized traffic compared against a queue-based FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo256_ctrl;

    localparam int WIDTH = 32;
    localparam int AFULL = 192;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [8:0]       level;
    logic             afull;
    logic             ovf;
    logic             unf;

    int checks   = 0;
    int failures = 0;

    // Reference model: a word queue and two sticky flags
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    bit               m_unf;

    fifo256_ctrl #(
        .WIDTH       (WIDTH),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .level    (level),
        .afull    (afull),
        .ovf      (ovf),
        .unf      (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the model
    task automatic check_all(input string tag);
        int sz;
        sz = m_q.size();
        check({tag, ".level"},    64'(level),    64'(sz));
        check({tag, ".wr_ready"}, 64'(wr_ready), 64'(sz != 256));
        check({tag, ".rd_valid"}, 64'(rd_valid), 64'(sz != 0));
        check({tag, ".afull"},    64'(afull),    64'(sz >= AFULL));
        check({tag, ".ovf"},      64'(ovf),      64'(m_ovf));
        check({tag, ".unf"},      64'(unf),      64'(m_unf));
        if (sz != 0) begin
            check({tag, ".rd_data"}, 64'(rd_data), 64'(m_q[0]));
        end
    endtask

    // Apply one cycle of inputs, advance the model, then check after the edge
    task automatic cycle(input string tag, input logic wv, input logic [WIDTH-1:0] wd,
                         input logic rr, input logic fl);
        bit full;
        bit empty;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        full  = (m_q.size() == 256);
        empty = (m_q.size() == 0);
        @(posedge clk);
        if (fl) begin
            m_q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (wv && full)  m_ovf = 1;
            if (rr && empty) m_unf = 1;
            if (rr && !empty) void'(m_q.pop_front());
            if (wv && !full)  m_q.push_back(wd);
        end
        #1;
        check_all(tag);
    endtask

    // Pulse reset between edges and check outputs while it is still low
    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #2;
        m_q.delete();
        m_ovf = 0;
        m_unf = 0;
        check_all(tag);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        m_ovf    = 0;
        m_unf    = 0;
        #3;
        check_all("reset");
        #4;
        reset_n = 1'b1;

        // Three pushes with consumer stalled, then drain
        cycle("p3", 1, 32'h11, 0, 0);
        cycle("p3", 1, 32'h22, 0, 0);
        cycle("p3", 1, 32'h33, 0, 0);
        check("p3.level3", 64'(level), 64'd3);
        check("p3.head",   64'(rd_data), 64'h11);
        for (int i = 0; i < 3; i++) cycle("drain3", 0, '0, 1, 0);
        check("drain3.empty", 64'(rd_valid), 64'd0);

        // Fill to 256, then push into a full FIFO
        for (int i = 0; i < 256; i++) cycle("fill", 1, WIDTH'(i), 0, 0);
        check("full.level", 64'(level), 64'd256);
        check("full.afull", 64'(afull), 64'd1);
        cycle("ovf", 1, 32'hDEAD_BEEF, 0, 0);
        check("ovf.flag", 64'(ovf), 64'd1);
        check("ovf.head_intact", 64'(rd_data), 64'd0);
        cycle("full_pp", 1, 32'hCAFE, 1, 0);
        check("full_pp.level", 64'(level), 64'd255);
        for (int i = 0; i < 255; i++) cycle("drain256", 0, '0, 1, 0);
        cycle("ovf_flush", 0, '0, 0, 1);

        // Steady-state push/pop at level 100 across pointer wrap
        for (int i = 0; i < 100; i++) cycle("fill100", 1, $urandom, 0, 0);
        for (int i = 0; i < 300; i++) cycle("pp100", 1, $urandom, 1, 0);
        check("pp100.level", 64'(level), 64'd100);
        cycle("pp100_flush", 0, '0, 0, 1);

        // Underflow then flush clears it
        cycle("empty_pp", 1, 32'h5A, 1, 0);
        check("empty_pp.level", 64'(level), 64'd1);
        cycle("empty_pp_pop", 0, '0, 1, 0);
        cycle("unf", 0, '0, 1, 0);
        check("unf.flag", 64'(unf), 64'd1);
        cycle("unf_flush", 0, '0, 0, 1);
        check("unf_flush.flag", 64'(unf), 64'd0);

        // Flush overrides simultaneous push and pop
        for (int i = 0; i < 50; i++) cycle("fill50", 1, $urandom, 0, 0);
        cycle("flush50", 1, 32'h77, 1, 1);
        check("flush50.level", 64'(level), 64'd0);

        // Mid-operation async reset discards contents
        for (int i = 0; i < 10; i++) cycle("fill10", 1, $urandom, 0, 0);
        async_reset("areset");
        cycle("post_reset", 1, 32'hAB, 0, 0);
        check("post_reset.head", 64'(rd_data), 64'hAB);

        // Randomized traffic in push-heavy, pop-heavy and balanced phases
        for (int i = 0; i < 3000; i++) begin
            int ph;
            int pw;
            int pr;
            ph = (i / 500) % 3;
            pw = (ph == 0) ? 90 : (ph == 1) ? 20 : 55;
            pr = (ph == 0) ? 20 : (ph == 1) ? 90 : 55;
            cycle("rand",
                  ($urandom_range(99) < pw),
                  $urandom,
                  ($urandom_range(99) < pr),
                  ($urandom_range(199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
